// File: rtl/iterative_alu.sv
// Registered multi-cycle ALU: single-cycle logic/arithmetic, bit-serial shifts, shift-add multiply.
// Define ALU_MUL_EN to build the iterative multiplier for code 15; otherwise code 15 returns 0 in one cycle.
module iterative_alu #(
    parameter int WIDTH = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [3:0]                FunSel,
    input  logic [WIDTH-1:0]          A,
    input  logic [WIDTH-1:0]          B,
    input  logic [$clog2(WIDTH)-1:0]  ShAmt,
    input  logic                      WF,
    output logic                      Busy,
    output logic                      Done,
    output logic [WIDTH-1:0]          ALUOut,
    output logic [3:0]                FlagsOut
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_MUL   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [3:0]       fun_q, fun_d;
    logic             wf_q, wf_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] opb, res;
    logic             cin;
    logic [WIDTH:0]   sum, step;
    logic             complete, wr, upd_c, upd_o, c_new, o_new;

    // One shift/rotate step: {bit shifted out, new value}
    function automatic logic [WIDTH:0] shift_step(input logic [3:0] code, input logic [WIDTH-1:0] x);
        case (code)
            4'd11:   shift_step = {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
            4'd12:   shift_step = {x[0], 1'b0, x[WIDTH-1:1]};
            4'd13:   shift_step = {x[0], x[WIDTH-1], x[WIDTH-1:1]};
            default: shift_step = {x[WIDTH-1], x[WIDTH-2:0], x[WIDTH-1]};
        endcase
    endfunction

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;

    // Accumulator holds {partial sum, remaining multiplier bits}; each step retires one multiplier bit
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc, input logic [WIDTH-1:0] mcand);
        logic [WIDTH:0] s;
        s = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        mul_step = {s, acc[WIDTH-1:1]};
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        fun_d    = fun_q;
        wf_d     = wf_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        complete = 1'b0;
        wr       = 1'b0;
        upd_c    = 1'b0;
        upd_o    = 1'b0;
        c_new    = 1'b0;
        o_new    = 1'b0;
        res      = '0;
        step     = '0;
`ifdef ALU_MUL_EN
        acc_d    = acc_q;
        prod     = acc_q;
`endif
        // Shared adder: subtraction is A + ~B + 1
        opb = (FunSel == 4'd6) ? ~B : B;
        cin = (FunSel == 4'd6) ? 1'b1 : ((FunSel == 4'd5) ? flags_q[2] : 1'b0);
        sum = {1'b0, A} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    fun_d = FunSel;
                    wf_d  = WF;
                    wr    = WF;
                    case (FunSel)
                        4'd0:  begin complete = 1'b1; res = A; end
                        4'd1:  begin complete = 1'b1; res = B; end
                        4'd2:  begin complete = 1'b1; res = ~A; end
                        4'd3:  begin complete = 1'b1; res = ~B; end
                        4'd4, 4'd5: begin
                            complete = 1'b1;
                            res   = sum[WIDTH-1:0];
                            upd_c = 1'b1;
                            upd_o = 1'b1;
                            c_new = sum[WIDTH];
                            o_new = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
                        end
                        4'd6: begin
                            complete = 1'b1;
                            res   = sum[WIDTH-1:0];
                            upd_c = 1'b1;
                            upd_o = 1'b1;
                            c_new = sum[WIDTH];
                            o_new = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
                        end
                        4'd7:  begin complete = 1'b1; res = A & B; end
                        4'd8:  begin complete = 1'b1; res = A | B; end
                        4'd9:  begin complete = 1'b1; res = A ^ B; end
                        4'd10: begin complete = 1'b1; res = ~(A & B); end
                        4'd11, 4'd12, 4'd13, 4'd14: begin
                            step = shift_step(FunSel, A);
                            if (ShAmt == '0) begin
                                complete = 1'b1;
                                res      = A;
                            end else if (ShAmt == SW'(1)) begin
                                complete = 1'b1;
                                res      = step[WIDTH-1:0];
                                upd_c    = 1'b1;
                                c_new    = step[WIDTH];
                            end else begin
                                a_d     = step[WIDTH-1:0];
                                cnt_d   = ShAmt - SW'(1);
                                state_d = S_SHIFT;
                            end
                        end
                        default: begin
`ifdef ALU_MUL_EN
                            prod    = mul_step({{WIDTH{1'b0}}, B}, A);
                            acc_d   = prod;
                            a_d     = A;
                            cnt_d   = '1;
                            state_d = S_MUL;
`else
                            complete = 1'b1;
                            res      = '0;
                            wr       = 1'b0;
`endif
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                step  = shift_step(fun_q, a_q);
                a_d   = step[WIDTH-1:0];
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    complete = 1'b1;
                    res      = step[WIDTH-1:0];
                    wr       = wf_q;
                    upd_c    = 1'b1;
                    c_new    = step[WIDTH];
                    state_d  = S_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                prod  = mul_step(acc_q, a_q);
                acc_d = prod;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    complete = 1'b1;
                    res      = prod[WIDTH-1:0];
                    wr       = wf_q;
                    upd_c    = 1'b1;
                    upd_o    = 1'b1;
                    c_new    = |prod[2*WIDTH-1:WIDTH];
                    o_new    = 1'b0;
                    state_d  = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            result_d = res;
            done_d   = 1'b1;
            if (wr) begin
                flags_d[3] = (res == '0);
                flags_d[1] = res[WIDTH-1];
                if (upd_c) flags_d[2] = c_new;
                if (upd_o) flags_d[0] = o_new;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            fun_q    <= '0;
            wf_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            fun_q    <= fun_d;
            wf_q     <= wf_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
`ifdef ALU_MUL_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign Busy     = (state_q != S_IDLE);
    assign Done     = done_q;
    assign ALUOut   = result_q;
    assign FlagsOut = flags_q;
endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu (WIDTH=16) with an expected-result queue and a behavioural flag model.
module tb_iterative_alu;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  FunSel = '0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  ShAmt = '0;
    logic        WF = 1'b0;
    logic        Busy, Done;
    logic [15:0] ALUOut;
    logic [3:0]  FlagsOut;

    iterative_alu #(.WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .FunSel(FunSel),
        .A(A), .B(B), .ShAmt(ShAmt), .WF(WF),
        .Busy(Busy), .Done(Done), .ALUOut(ALUOut), .FlagsOut(FlagsOut)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mf = '0;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Behavioural reference: full-width operators, flags per operation class
    task automatic model_push(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                              input int sh, input logic w);
        logic [16:0] s;
        logic [31:0] a32, b32, p;
        logic [15:0] r;
        logic        c, o, upd;
        exp_t        e;
        c = mf[2]; o = mf[0]; upd = w; r = '0; s = '0;
        a32 = {16'h0, a}; b32 = {16'h0, b};
        e.lat = 1;
        case (f)
            4'd0: r = a;
            4'd1: r = b;
            4'd2: r = ~a;
            4'd3: r = ~b;
            4'd4, 4'd5: begin
                s = {1'b0, a} + {1'b0, b} + ((f == 4'd5) ? {16'h0, mf[2]} : 17'h0);
                r = s[15:0]; c = s[16];
                o = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'd6: begin
                r = a - b; c = (a >= b);
                o = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd7:  r = a & b;
            4'd8:  r = a | b;
            4'd9:  r = a ^ b;
            4'd10: r = ~(a & b);
            4'd11: begin r = a << sh; if (sh != 0) c = a[16-sh]; end
            4'd12: begin r = a >> sh; if (sh != 0) c = a[sh-1]; end
            4'd13: begin r = $signed(a) >>> sh; if (sh != 0) c = a[sh-1]; end
            4'd14: begin r = (a << sh) | (a >> (16 - sh)); if (sh != 0) c = a[16-sh]; end
            default: begin
`ifdef ALU_MUL_EN
                p = a32 * b32;
                r = p[15:0]; c = |p[31:16]; o = 1'b0;
                e.lat = 16;
`else
                p = '0;
                r = '0; upd = 1'b0;
`endif
            end
        endcase
        if (f >= 4'd11 && f <= 4'd14 && sh > 1) e.lat = sh;
        if (upd) mf = {(r == 16'h0), c, r[15], o};
        e.res = r;
        e.flg = mf;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                          input int sh, input logic w, input bit scramble);
        int   cyc;
        exp_t e;
        @(negedge Clock);
        FunSel = f; A = a; B = b; ShAmt = 4'(sh); WF = w; Start = 1'b1;
        model_push(f, a, b, sh, w);
        @(posedge Clock); #1;
        Start = 1'b0;
        cyc = 1;
        while (!Done && cyc < 40) begin
            check("busy_during_op", {31'h0, Busy}, 32'h1);
            if (scramble) begin
                A = 16'($urandom); B = 16'($urandom); FunSel = 4'($urandom);
                ShAmt = 4'($urandom); WF = 1'($urandom); Start = 1'b1;
            end
            @(posedge Clock); #1;
            cyc++;
        end
        Start = 1'b0;
        e = sb.pop_front();
        $display("op f=%0d a=%h b=%h sh=%0d wf=%0b -> out=%h flags=%b lat=%0d (exp %h %b %0d)",
                 f, a, b, sh, w, ALUOut, FlagsOut, cyc, e.res, e.flg, e.lat);
        check("done_seen", {31'h0, Done}, 32'h1);
        check("latency", cyc, e.lat);
        check("busy_at_done", {31'h0, Busy}, 32'h0);
        check("aluout", {16'h0, ALUOut}, {16'h0, e.res});
        check("flags", {28'h0, FlagsOut}, {28'h0, e.flg});
        @(posedge Clock); #1;
        check("done_pulse_width", {31'h0, Done}, 32'h0);
    endtask

    initial begin
        int   cyc;
        int   dones;
        exp_t e;

        #12;
        check("rst_aluout", {16'h0, ALUOut}, 32'h0);
        check("rst_flags", {28'h0, FlagsOut}, 32'h0);
        check("rst_busy", {31'h0, Busy}, 32'h0);
        check("rst_done", {31'h0, Done}, 32'h0);
        @(negedge Clock); Reset = 1'b1;

        run_op(4'd4,  16'h7FFF, 16'h0001, 0, 1'b1, 1'b0);
        run_op(4'd6,  16'h0005, 16'h0005, 0, 1'b1, 1'b0);
        run_op(4'd6,  16'h0003, 16'h0009, 0, 1'b0, 1'b0);
        run_op(4'd11, 16'h1001, 16'h0000, 4, 1'b1, 1'b1);
        run_op(4'd5,  16'h0001, 16'h0002, 0, 1'b1, 1'b0);
        run_op(4'd4,  16'hFFFF, 16'h0001, 0, 1'b1, 1'b0);
        run_op(4'd5,  16'h1000, 16'h0234, 0, 1'b1, 1'b0);
        run_op(4'd6,  16'h8000, 16'h0001, 0, 1'b1, 1'b0);
        run_op(4'd0,  16'h0000, 16'h1234, 0, 1'b1, 1'b0);
        run_op(4'd1,  16'h0000, 16'h8421, 0, 1'b1, 1'b0);
        run_op(4'd2,  16'h00FF, 16'h0000, 0, 1'b1, 1'b0);
        run_op(4'd3,  16'h0000, 16'hFFFF, 0, 1'b1, 1'b0);
        run_op(4'd7,  16'hF0F0, 16'h3C3C, 0, 1'b1, 1'b0);
        run_op(4'd8,  16'hF0F0, 16'h0F0F, 0, 1'b1, 1'b0);
        run_op(4'd9,  16'hAAAA, 16'hAAAA, 0, 1'b1, 1'b0);
        run_op(4'd10, 16'hFFFF, 16'h00FF, 0, 1'b1, 1'b0);
        run_op(4'd12, 16'h8421, 16'h0000, 0, 1'b1, 1'b0);
        run_op(4'd14, 16'h8001, 16'h0000, 1, 1'b1, 1'b0);
        run_op(4'd12, 16'hF00F, 16'h0000, 5, 1'b1, 1'b1);
        run_op(4'd13, 16'h8080, 16'h0000, 7, 1'b1, 1'b0);
        run_op(4'd14, 16'hC003, 16'h0000, 15, 1'b1, 1'b0);
        run_op(4'd11, 16'h00FF, 16'h0000, 9, 1'b0, 1'b0);
        run_op(4'd15, 16'h0100, 16'h0100, 0, 1'b1, 1'b1);
        run_op(4'd15, 16'h0003, 16'h0005, 0, 1'b1, 1'b0);
        run_op(4'd15, 16'hFFFF, 16'hFFFF, 0, 1'b1, 1'b0);

        // Back-to-back: issue an add in the same cycle the shift reports Done
        @(negedge Clock);
        FunSel = 4'd12; A = 16'hF000; B = 16'h0; ShAmt = 4'd3; WF = 1'b1; Start = 1'b1;
        model_push(4'd12, 16'hF000, 16'h0, 3, 1'b1);
        @(posedge Clock); #1;
        Start = 1'b0;
        cyc = 1;
        while (!Done && cyc < 40) begin
            @(posedge Clock); #1;
            cyc++;
        end
        FunSel = 4'd4; A = 16'h0001; B = 16'h0002; WF = 1'b1; Start = 1'b1;
        model_push(4'd4, 16'h0001, 16'h0002, 0, 1'b1);
        e = sb.pop_front();
        $display("b2b shift -> out=%h flags=%b lat=%0d (exp %h %b %0d)", ALUOut, FlagsOut, cyc, e.res, e.flg, e.lat);
        check("b2b_shift_latency", cyc, e.lat);
        check("b2b_shift_out", {16'h0, ALUOut}, {16'h0, e.res});
        @(posedge Clock); #1;
        Start = 1'b0;
        e = sb.pop_front();
        $display("b2b add -> done=%0b out=%h flags=%b (exp %h %b)", Done, ALUOut, FlagsOut, e.res, e.flg);
        check("b2b_add_done", {31'h0, Done}, 32'h1);
        check("b2b_add_out", {16'h0, ALUOut}, {16'h0, e.res});
        check("b2b_add_flags", {28'h0, FlagsOut}, {28'h0, e.flg});

        // Reset in the middle of a long operation
        @(negedge Clock);
        FunSel = 4'd12; A = 16'h8000; ShAmt = 4'd15; WF = 1'b1; Start = 1'b1;
        model_push(4'd12, 16'h8000, 16'h0, 15, 1'b1);
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (5) @(posedge Clock);
        #1;
        check("abort_busy_before", {31'h0, Busy}, 32'h1);
        #2 Reset = 1'b0;
        #1;
        $display("abort -> out=%h flags=%b busy=%0b done=%0b", ALUOut, FlagsOut, Busy, Done);
        check("abort_aluout", {16'h0, ALUOut}, 32'h0);
        check("abort_flags", {28'h0, FlagsOut}, 32'h0);
        check("abort_busy", {31'h0, Busy}, 32'h0);
        check("abort_done", {31'h0, Done}, 32'h0);
        void'(sb.pop_front());
        mf = '0;
        @(negedge Clock); Reset = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge Clock); #1;
            if (Done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(4'd5, 16'hFFFF, 16'h0001, 0, 1'b1, 1'b0);
        run_op(4'd13, 16'h8001, 16'h0000, 2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
